// File: rtl/mdio_slave.sv
// -----------------------------------------------------------------------------
// mdio_slave
//   MDIO management-frame responder. MDC and MDIO are oversampled on the system
//   clock: both pass through a synchronizer and MDC edges become one-clk rise /
//   fall events. Incoming bits are taken on rise events, the pad is only ever
//   changed on fall events. A frame needs a full preamble of ones, a matching
//   PHY address and a legal opcode before any register strobe is issued.
//
// Ports
//   clk        system clock (>= 8x MDC)
//   rst        asynchronous active-high reset
//   mdc        management clock from the station (asynchronous)
//   mdio_i     pad input
//   mdio_o     pad output data (idles at 1)
//   mdio_oe    pad output enable, 1 = drive
//   phy_addr   address this responder answers to
//   reg_addr   register address of the current frame
//   reg_wdata  write data, valid while reg_we is high
//   reg_we     one-clk write strobe
//   reg_re     one-clk read strobe
//   reg_rdata  read data, sampled one clk after reg_re
// -----------------------------------------------------------------------------
module mdio_slave #(
  parameter int PREAMBLE_MIN = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [4:0]  phy_addr,
  output logic [4:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ST    = 3'd1,
    S_OP    = 3'd2,
    S_PHYAD = 3'd3,
    S_REGAD = 3'd4,
    S_TA    = 3'd5,
    S_DATA  = 3'd6
  } state_t;

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
  localparam logic [5:0] PRE_MAX = 6'h3F;

  logic [SYNC_STAGES-1:0] mdc_sync_q;
  logic [SYNC_STAGES-1:0] mdio_sync_q;
  logic                   mdc_prev_q;

  logic        mdc_now;
  logic        mdio_bit;
  logic        mdc_rise;
  logic        mdc_fall;
  logic [15:0] shift_d;

  state_t      state_q;
  logic [5:0]  pre_cnt_q;
  logic [4:0]  bit_cnt_q;
  logic [14:0] shift_q;
  logic [15:0] tx_q;
  logic        is_read_q;
  logic        rd_cap_q;
  logic        mdio_o_q;
  logic        mdio_oe_q;
  logic        reg_we_q;
  logic        reg_re_q;
  logic [4:0]  reg_addr_q;
  logic [15:0] reg_wdata_q;

  assign mdc_now  = mdc_sync_q[SYNC_STAGES-1];
  assign mdio_bit = mdio_sync_q[SYNC_STAGES-1];
  assign mdc_rise = mdc_now & ~mdc_prev_q;
  assign mdc_fall = ~mdc_now & mdc_prev_q;
  // Receive shifter including the bit being sampled right now.
  assign shift_d  = {shift_q, mdio_bit};

  assign mdio_o    = mdio_o_q;
  assign mdio_oe   = mdio_oe_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;

  // Synchronizers for MDC/MDIO plus the previous MDC value for edge events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync_q  <= '1;
      mdio_sync_q <= '1;
      mdc_prev_q  <= 1'b1;
    end else begin
      mdc_sync_q[0]  <= mdc;
      mdio_sync_q[0] <= mdio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mdc_sync_q[i]  <= mdc_sync_q[i-1];
        mdio_sync_q[i] <= mdio_sync_q[i-1];
      end
      mdc_prev_q <= mdc_now;
    end
  end

  // Frame FSM: decodes on MDC rise events, drives the pad on MDC fall events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= 6'd0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 15'd0;
      tx_q        <= 16'hFFFF;
      is_read_q   <= 1'b0;
      rd_cap_q    <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= 5'd0;
      reg_wdata_q <= 16'd0;
    end else begin
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      // Register file answers one clk after the read strobe.
      rd_cap_q <= reg_re_q;
      if (rd_cap_q) begin
        tx_q <= reg_rdata;
      end
      // Outside IDLE the preamble count is always zero, so every return to
      // IDLE demands a fresh full preamble.
      if (state_q != S_IDLE) begin
        pre_cnt_q <= 6'd0;
      end
      case (state_q)
        S_IDLE: begin
          if (mdc_rise) begin
            if (mdio_bit) begin
              if (pre_cnt_q != PRE_MAX) begin
                pre_cnt_q <= pre_cnt_q + 6'd1;
              end
            end else begin
              // This zero is the first start bit when the preamble was long enough.
              pre_cnt_q <= 6'd0;
              if (pre_cnt_q >= PRE_MIN) begin
                state_q <= S_ST;
              end
            end
          end
        end
        S_ST: begin
          if (mdc_rise) begin
            bit_cnt_q <= 5'd0;
            state_q   <= mdio_bit ? S_OP : S_IDLE;
          end
        end
        S_OP: begin
          if (mdc_rise) begin
            shift_q <= shift_d[14:0];
            if (bit_cnt_q == 5'd1) begin
              bit_cnt_q <= 5'd0;
              case (shift_d[1:0])
                2'b10: begin
                  is_read_q <= 1'b1;
                  state_q   <= S_PHYAD;
                end
                2'b01: begin
                  is_read_q <= 1'b0;
                  state_q   <= S_PHYAD;
                end
                default: state_q <= S_IDLE;
              endcase
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        S_PHYAD: begin
          if (mdc_rise) begin
            shift_q <= shift_d[14:0];
            if (bit_cnt_q == 5'd4) begin
              bit_cnt_q <= 5'd0;
              state_q   <= (shift_d[4:0] == phy_addr) ? S_REGAD : S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        S_REGAD: begin
          if (mdc_rise) begin
            shift_q <= shift_d[14:0];
            if (bit_cnt_q == 5'd4) begin
              bit_cnt_q  <= 5'd0;
              reg_addr_q <= shift_d[4:0];
              reg_re_q   <= is_read_q;
              state_q    <= S_TA;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        S_TA: begin
          if (is_read_q) begin
            // bit_cnt: 0 = waiting TA1 rise, 1 = waiting fall to drive TA2,
            // 2 = waiting TA2 rise.
            if (mdc_rise && (bit_cnt_q == 5'd0)) begin
              bit_cnt_q <= 5'd1;
            end else if (mdc_fall && (bit_cnt_q == 5'd1)) begin
              mdio_oe_q <= 1'b1;
              mdio_o_q  <= 1'b0;
              bit_cnt_q <= 5'd2;
            end else if (mdc_rise && (bit_cnt_q == 5'd2)) begin
              bit_cnt_q <= 5'd0;
              state_q   <= S_DATA;
            end
          end else if (mdc_rise) begin
            shift_q <= shift_d[14:0];
            if (bit_cnt_q == 5'd1) begin
              bit_cnt_q <= 5'd0;
              state_q   <= (shift_d[1:0] == 2'b10) ? S_DATA : S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        S_DATA: begin
          if (is_read_q) begin
            // Falls 0..15 present D15..D0; fall 16 (after the D0 rise) releases.
            if (mdc_fall) begin
              if (bit_cnt_q == 5'd16) begin
                mdio_oe_q <= 1'b0;
                mdio_o_q  <= 1'b1;
                bit_cnt_q <= 5'd0;
                state_q   <= S_IDLE;
              end else begin
                mdio_o_q  <= tx_q[15];
                tx_q      <= {tx_q[14:0], 1'b1};
                bit_cnt_q <= bit_cnt_q + 5'd1;
              end
            end
          end else if (mdc_rise) begin
            shift_q <= shift_d[14:0];
            if (bit_cnt_q == 5'd15) begin
              reg_wdata_q <= shift_d;
              reg_we_q    <= 1'b1;
              bit_cnt_q   <= 5'd0;
              state_q     <= S_IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          bit_cnt_q <= 5'd0;
          mdio_oe_q <= 1'b0;
          mdio_o_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_slave.sv
// -----------------------------------------------------------------------------
// tb_mdio_slave
//   Station-side bench for mdio_slave. A station task toggles MDC (12 clk per
//   bit) and drives/samples a pulled-up MDIO bus. Directed frames come from a
//   table of records with hand-derived expectations; random frames get their
//   expectations from a frame-level reference model. A register-file model
//   returns read data only in the clk after reg_re (garbage otherwise).
// -----------------------------------------------------------------------------
module tb_mdio_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  phy_addr;
  logic [4:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;

  logic st_oe;
  logic st_val;

  // Shared bus with pull-up: responder has priority, then station, else 1.
  assign mdio_i = mdio_oe ? mdio_o : (st_oe ? st_val : 1'b1);

  always #5 clk = ~clk;

  mdio_slave #(.PREAMBLE_MIN(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mdc       (mdc),
    .mdio_i    (mdio_i),
    .mdio_o    (mdio_o),
    .mdio_oe   (mdio_oe),
    .phy_addr  (phy_addr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata)
  );

  typedef struct {
    int unsigned pre_len;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [1:0]  ta;
    logic [15:0] data;      // write data, or register contents for a read
    logic        exp_we;
    logic        exp_re;
    logic [4:0]  exp_addr;
    logic [15:0] exp_val;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  int          we_cnt, re_cnt, both_cnt, oe_cnt, contention;
  logic [4:0]  we_addr, re_addr;
  logic [15:0] we_data;
  logic [15:0] rd_val;
  logic        re_prev;
  logic [17:0] smp_oe, smp_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Strobe monitor and one-clk-latency register file.
  initial begin
    re_prev   = 1'b0;
    reg_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (reg_we) begin
        we_cnt++;
        we_addr = reg_addr;
        we_data = reg_wdata;
      end
      if (reg_re) begin
        re_cnt++;
        re_addr = reg_addr;
      end
      if (reg_we && reg_re) both_cnt++;
      if (mdio_oe) oe_cnt++;
      reg_rdata = re_prev ? rd_val : 16'($urandom);
      re_prev   = reg_re;
    end
  end

  // One MDC period: fall, station sets its bit, sample bus just before rise.
  task automatic mdc_bit(input logic drv, input logic val);
    @(negedge clk);
    mdc    = 1'b0;
    st_oe  = drv;
    st_val = val;
    repeat (6) @(negedge clk);
    if (st_oe && mdio_oe) contention++;
    smp_oe = {smp_oe[16:0], mdio_oe};
    smp_o  = {smp_o[16:0], mdio_o};
    mdc = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_field(input logic [15:0] v, input int n, input logic drv);
    for (int i = n - 1; i >= 0; i--) mdc_bit(drv, v[i]);
  endtask

  task automatic send_header(input vec_t v);
    for (int i = 0; i < int'(v.pre_len); i++) mdc_bit(1'b1, 1'b1);
    send_field({14'd0, v.st}, 2, 1'b1);
    send_field({14'd0, v.op}, 2, 1'b1);
    send_field({11'd0, v.phyad}, 5, 1'b1);
    send_field({11'd0, v.regad}, 5, 1'b1);
  endtask

  task automatic run_frame(input string tag, input vec_t v);
    logic [17:0] rd_oe;
    logic [17:0] rd_o;
    logic        post_oe;
    rd_val     = v.data;
    we_cnt     = 0;
    re_cnt     = 0;
    both_cnt   = 0;
    oe_cnt     = 0;
    contention = 0;
    send_header(v);
    if (v.op == 2'b10) begin
      send_field(16'hFFFF, 2, 1'b0);
      send_field(16'hFFFF, 16, 1'b0);
    end else begin
      send_field({14'd0, v.ta}, 2, 1'b1);
      send_field(v.data, 16, 1'b1);
    end
    rd_oe = smp_oe;
    rd_o  = smp_o;
    mdc_bit(1'b0, 1'b1);          // idle bit: responder must have released
    post_oe = smp_oe[0];
    mdc_bit(1'b1, 1'b0);          // guard zero isolates the next frame
    st_oe = 1'b0;
    chk($sformatf("%s we_count", tag), 32'(we_cnt), 32'(v.exp_we));
    chk($sformatf("%s re_count", tag), 32'(re_cnt), 32'(v.exp_re));
    chk($sformatf("%s strobe_overlap", tag), 32'(both_cnt), 32'd0);
    chk($sformatf("%s contention", tag), 32'(contention), 32'd0);
    if (v.exp_we) begin
      chk($sformatf("%s wr_addr", tag), 32'(we_addr), 32'(v.exp_addr));
      chk($sformatf("%s wr_data", tag), 32'(we_data), 32'(v.exp_val));
    end
    if (v.exp_re) begin
      chk($sformatf("%s rd_addr", tag), 32'(re_addr), 32'(v.exp_addr));
      chk($sformatf("%s pad_oe", tag), 32'(rd_oe), 32'h1FFFF);
      chk($sformatf("%s pad_data", tag), 32'(rd_o[16:0]), {15'd0, 1'b0, v.exp_val});
      chk($sformatf("%s oe_after_d0", tag), 32'(post_oe), 32'd0);
    end else begin
      chk($sformatf("%s oe_never", tag), 32'(oe_cnt), 32'd0);
    end
  endtask

  // Frame-level reference: which frames the responder must act on.
  function automatic vec_t model(input vec_t v, input logic [4:0] pa);
    vec_t r;
    logic acc;
    r = v;
    acc = (v.pre_len >= 32) && (v.st == 2'b01) &&
          ((v.op == 2'b10) || (v.op == 2'b01)) && (v.phyad == pa);
    r.exp_we   = acc && (v.op == 2'b01) && (v.ta == 2'b10);
    r.exp_re   = acc && (v.op == 2'b10);
    r.exp_addr = v.regad;
    r.exp_val  = v.data;
    return r;
  endfunction

  vec_t tbl [11];
  vec_t rv;
  vec_t mid;

  initial begin
    //           pre  st     op     phy    reg     ta     data      we    re    addr    val
    tbl[0]  = '{32, 2'b01, 2'b01, 5'd3, 5'd5,  2'b10, 16'hA5C3, 1'b1, 1'b0, 5'd5,  16'hA5C3};
    tbl[1]  = '{32, 2'b01, 2'b10, 5'd3, 5'd2,  2'b00, 16'h1234, 1'b0, 1'b1, 5'd2,  16'h1234};
    tbl[2]  = '{32, 2'b01, 2'b10, 5'd4, 5'd2,  2'b00, 16'h5555, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[3]  = '{31, 2'b01, 2'b01, 5'd3, 5'd7,  2'b10, 16'hBEEF, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[4]  = '{32, 2'b01, 2'b01, 5'd3, 5'd7,  2'b10, 16'hBEEF, 1'b1, 1'b0, 5'd7,  16'hBEEF};
    tbl[5]  = '{32, 2'b01, 2'b01, 5'd3, 5'd9,  2'b11, 16'h1111, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[6]  = '{32, 2'b01, 2'b11, 5'd3, 5'd9,  2'b10, 16'h2222, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[7]  = '{32, 2'b01, 2'b01, 5'd3, 5'd31, 2'b10, 16'hFFFF, 1'b1, 1'b0, 5'd31, 16'hFFFF};
    tbl[8]  = '{32, 2'b01, 2'b10, 5'd3, 5'd0,  2'b00, 16'h0000, 1'b0, 1'b1, 5'd0,  16'h0000};
    tbl[9]  = '{40, 2'b00, 2'b01, 5'd3, 5'd4,  2'b10, 16'h3C3C, 1'b0, 1'b0, 5'd0,  16'h0000};
    tbl[10] = '{70, 2'b01, 2'b10, 5'd3, 5'd31, 2'b00, 16'h8001, 1'b0, 1'b1, 5'd31, 16'h8001};

    rst      = 1'b1;
    mdc      = 1'b1;
    st_oe    = 1'b0;
    st_val   = 1'b1;
    phy_addr = 5'd3;
    rd_val   = 16'h0000;
    smp_oe   = 18'd0;
    smp_o    = 18'd0;
    repeat (3) @(negedge clk);
    chk("reset mdio_oe", 32'(mdio_oe), 32'd0);
    chk("reset mdio_o", 32'(mdio_o), 32'd1);
    chk("reset reg_we", 32'(reg_we), 32'd0);
    chk("reset reg_re", 32'(reg_re), 32'd0);
    chk("reset reg_addr", 32'(reg_addr), 32'd0);
    chk("reset reg_wdata", 32'(reg_wdata), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_frame($sformatf("vec%0d", i), tbl[i]);
    end

    // Reset in the middle of read data: pad must let go without a clock edge.
    phy_addr = 5'd3;
    mid = '{32, 2'b01, 2'b10, 5'd3, 5'd12, 2'b00, 16'h9E37, 1'b0, 1'b1, 5'd12, 16'h9E37};
    rd_val = mid.data;
    send_header(mid);
    send_field(16'hFFFF, 2, 1'b0);
    send_field(16'hFFFF, 8, 1'b0);
    chk("rst_mid driving_before", 32'(smp_oe[0]), 32'd1);
    @(negedge clk);
    mdc = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid oe_async", 32'(mdio_oe), 32'd0);
    chk("rst_mid o_async", 32'(mdio_o), 32'd1);
    repeat (3) @(negedge clk);
    mdc = 1'b1;
    chk("rst_mid reg_addr", 32'(reg_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_frame("rst_mid after", mid);

    // Randomized frames against the reference model.
    for (int n = 0; n < 30; n++) begin
      phy_addr   = 5'($urandom);
      rv.pre_len = $urandom_range(28, 40);
      rv.st      = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01;
      case ($urandom_range(0, 5))
        0:       rv.op = 2'b00;
        1:       rv.op = 2'b11;
        2, 3:    rv.op = 2'b10;
        default: rv.op = 2'b01;
      endcase
      rv.phyad = ($urandom_range(0, 3) == 0) ? 5'($urandom) : phy_addr;
      rv.regad = 5'($urandom);
      rv.ta    = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b10;
      rv.data  = 16'($urandom);
      rv = model(rv, phy_addr);
      run_frame($sformatf("rnd%0d", n), rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
